tcp_rx_checker: RTL and testbench
=================================

# tcp_rx_checker

Multi-session, width-parametrised TCP receive benchmark checker. It sits behind the TCP/IP stack's RX metadata/data interface on the benchmark path. It tracks per-session message boundaries across arbitrary packet splits and verifies a counting data pattern. It reports throughput cycles, error statistics and completion to the control/status register bank.

## Interface
Parameters:
- DATA_WIDTH, 512, RX data bus width in bits; power of two, ≥64.
- NUM_SESSIONS, 4, number of tracked sessions; power of two, 1..64.
- SID_WIDTH, 16, width of the session ID field in metadata.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_meta_valid  in  1  RX metadata valid.
- s_meta_ready  out  1  RX metadata ready.
- s_meta_sid  in  SID_WIDTH  session ID of the following packet.
- s_data_valid  in  1  RX data beat valid.
- s_data_ready  out  1  RX data ready.
- s_data_data  in  DATA_WIDTH  beat payload; bits [31:0] carry the pattern word.
- s_data_last  in  1  last beat of the packet.
- start  in  1  single-cycle pulse; captures the config and clears all statistics.
- cfg_msg_len  in  32  message length in bytes.
- cfg_ops  in  32  total messages (all sessions) to finish the run.
- cfg_offset  in  32  pattern offset.
- cfg_check_en  in  1  1 = compare the pattern, 0 = count only.
- stat_cycles  out  32  throughput cycle count.
- stat_err_cnt  out  32  mismatching beats.
- stat_err_index  out  32  beat index of the most recent mismatch.
- stat_err_sid  out  SID_WIDTH  session of the most recent mismatch.
- stat_word_cnt  out  32  total accepted data beats.
- stat_msg_cnt  out  32  completed messages.
- stat_bad_sid_cnt  out  32  packets whose SID ≥ NUM_SESSIONS.
- done  out  1  run complete, level.

## Operation
- Config registers (len, ops, offset, check_en) load only on `start`.
  - BPB = DATA_WIDTH/8.
  - beats = cfg_msg_len >> log2(BPB).
  - last_idx = (beats==0) ? 0 : beats−1. This is registered, valid the cycle after `start`.
- FSM states: IDLE, META, DATA, DONE. Reset state is IDLE.
  - IDLE: both readies are 0. `start` → META.
  - META: s_meta_ready=1. On handshake, latch the SID → DATA. The first handshake of a run arms the timer.
  - DATA: s_data_ready=1. On a beat with last=1 → META. If, on that beat, msg_cnt+completed == cfg_ops → DONE instead.
  - DONE: readies are 0, done=1. `start` → META with statistics cleared.
- Per-session beat counter beat_cnt[sid], width 32, NUM_SESSIONS entries.
  - On each accepted beat with a valid SID: if beat_cnt==last_idx, it wraps to 0 and msg_cnt increments. Otherwise it increments.
  - A message may span several packets, and packets of different sessions may interleave at packet granularity.
- Pattern check happens on each accepted beat with a valid SID when check_en=1.
  - Expected: s_data_data[31:0] == beat_cnt[sid] + cfg_offset, mod 2^32.
  - On mismatch: err_cnt+1, err_index ← beat_cnt[sid], err_sid ← sid.
- Invalid SID (≥ NUM_SESSIONS):
  - Packet is still drained.
  - stat_bad_sid_cnt+1 at metadata accept.
  - Beats count in word_cnt only: no check, no beat_cnt or msg_cnt update.
- word_cnt increments on every accepted data beat.
- cfg_ops==0: the first metadata is accepted and its packet drained, then → DONE after the packet's last beat.
- `start` in any state restarts the run: all beat_cnt, all stats, done and timer clear, → META. Any in-flight packet remainder is then treated as data of the next packet's session. The driver must not pulse `start` mid-packet.
- Reset: all state and outputs clear, FSM → IDLE, readies 0, done 0.

## Timing
- Readies are registered state decodes: valid from the cycle after the state entry.
- All statistics update the cycle after the qualifying handshake.
- Timer:
  - Increments every cycle from the cycle after the first META handshake through the cycle of the final beat's handshake, inclusive.
  - Frozen in DONE.
  - Wraps at 2^32.
- `done` rises the cycle after the final beat's handshake.
- Config is usable from 2 cycles after `start`. The driver must not present metadata before that.
- Back-to-back: one beat per cycle in DATA. Packet-to-packet costs one META cycle.

## Test plan
1. DATA_WIDTH=512, len=4096 (64 beats), ops=4, sid=0, offset=0, one 64-beat packet per message, pattern correct → done=1, msg_cnt=4, word_cnt=256, err_cnt=0, stat_cycles = 256 + 3 META cycles.
2. Same config with beat 10 of message 2 carrying word 0xDEAD → err_cnt=1, err_index=10, err_sid=0. Repeat with check_en=0 → err_cnt=0.
3. Two sessions interleaved, each 64-beat message split into 16-beat packets alternating sid0/sid1, ops=4, offset=0x100 → err_cnt=0, msg_cnt=4, beat_cnt of both sessions 0 at done.
4. Metadata sid=NUM_SESSIONS with an 8-beat packet, then a normal run → bad_sid_cnt=1, word_cnt includes the 8 beats, msg_cnt unaffected, err_cnt=0.
5. len=32 (<BPB, so last_idx=0), ops=3, three 1-beat packets → done after the third beat, msg_cnt=3. Then a `start` pulse in DONE → all stats 0, done=0, s_meta_ready=1 the next cycle.
6. rstn low for one cycle mid-packet → next cycle all outputs 0, FSM IDLE, s_data_ready=0.

Source files
------------

// File: rtl/tcp_rx_checker.sv
// TCP RX benchmark checker: tracks per-session message boundaries across packet
// splits, verifies a counting pattern in bits [31:0] of each beat, and keeps run statistics.
module tcp_rx_checker #(
    parameter int DATA_WIDTH   = 512,
    parameter int NUM_SESSIONS = 4,
    parameter int SID_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_meta_valid,
    output logic                  s_meta_ready,
    input  logic [SID_WIDTH-1:0]  s_meta_sid,
    input  logic                  s_data_valid,
    output logic                  s_data_ready,
    input  logic [DATA_WIDTH-1:0] s_data_data,
    input  logic                  s_data_last,
    input  logic                  start,
    input  logic [31:0]           cfg_msg_len,
    input  logic [31:0]           cfg_ops,
    input  logic [31:0]           cfg_offset,
    input  logic                  cfg_check_en,
    output logic [31:0]           stat_cycles,
    output logic [31:0]           stat_err_cnt,
    output logic [31:0]           stat_err_index,
    output logic [SID_WIDTH-1:0]  stat_err_sid,
    output logic [31:0]           stat_word_cnt,
    output logic [31:0]           stat_msg_cnt,
    output logic [31:0]           stat_bad_sid_cnt,
    output logic                  done
);
    localparam int BPB   = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BPB);
    localparam int IDX_W = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_META, ST_DATA, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic                 meta_ready_q, meta_ready_d;
    logic                 data_ready_q, data_ready_d;
    logic                 done_q, done_d;
    logic [31:0]          last_idx_q, last_idx_d;
    logic [31:0]          ops_q, ops_d;
    logic [31:0]          offset_q, offset_d;
    logic                 check_en_q, check_en_d;
    logic [SID_WIDTH-1:0] sid_q, sid_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 sid_ok_q, sid_ok_d;
    logic                 armed_q, armed_d;
    logic [31:0]          cycles_q, cycles_d;
    logic [31:0]          err_cnt_q, err_cnt_d;
    logic [31:0]          err_index_q, err_index_d;
    logic [SID_WIDTH-1:0] err_sid_q, err_sid_d;
    logic [31:0]          word_cnt_q, word_cnt_d;
    logic [31:0]          msg_cnt_q, msg_cnt_d;
    logic [31:0]          bad_sid_cnt_q, bad_sid_cnt_d;
    logic [31:0]          beat_cnt_q [NUM_SESSIONS];
    logic [31:0]          beat_cnt_d [NUM_SESSIONS];

    logic        meta_hs, data_hs, meta_sid_ok, completed;
    logic [31:0] beats, cur_cnt, exp_word;
    logic        unused_data_bits;

    assign meta_hs     = meta_ready_q & s_meta_valid;
    assign data_hs     = data_ready_q & s_data_valid;
    assign meta_sid_ok = ({1'b0, s_meta_sid} < (SID_WIDTH + 1)'(NUM_SESSIONS));
    assign beats       = cfg_msg_len >> SHIFT;
    assign cur_cnt     = beat_cnt_q[idx_q];
    assign exp_word    = cur_cnt + offset_q;
    assign unused_data_bits = ^s_data_data[DATA_WIDTH-1:32];

    always_comb begin
        state_d       = state_q;
        last_idx_d    = last_idx_q;
        ops_d         = ops_q;
        offset_d      = offset_q;
        check_en_d    = check_en_q;
        sid_d         = sid_q;
        idx_d         = idx_q;
        sid_ok_d      = sid_ok_q;
        armed_d       = armed_q;
        cycles_d      = cycles_q;
        err_cnt_d     = err_cnt_q;
        err_index_d   = err_index_q;
        err_sid_d     = err_sid_q;
        word_cnt_d    = word_cnt_q;
        msg_cnt_d     = msg_cnt_q;
        bad_sid_cnt_d = bad_sid_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        completed     = 1'b0;

        // Timer runs from the cycle after the first metadata handshake until DONE.
        if (armed_q && (state_q == ST_META || state_q == ST_DATA))
            cycles_d = cycles_q + 32'd1;

        case (state_q)
            ST_META: begin
                if (meta_hs) begin
                    sid_d    = s_meta_sid;
                    idx_d    = s_meta_sid[IDX_W-1:0];
                    sid_ok_d = meta_sid_ok;
                    armed_d  = 1'b1;
                    if (!meta_sid_ok)
                        bad_sid_cnt_d = bad_sid_cnt_q + 32'd1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_hs) begin
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (sid_ok_q) begin
                        completed = (cur_cnt == last_idx_q);
                        beat_cnt_d[idx_q] = completed ? 32'd0 : cur_cnt + 32'd1;
                        if (completed)
                            msg_cnt_d = msg_cnt_q + 32'd1;
                        if (check_en_q && (s_data_data[31:0] != exp_word)) begin
                            err_cnt_d   = err_cnt_q + 32'd1;
                            err_index_d = cur_cnt;
                            err_sid_d   = sid_q;
                        end
                    end
                    if (s_data_last)
                        state_d = ((msg_cnt_q + 32'(completed)) == ops_q) ? ST_DONE : ST_META;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d       = ST_META;
            last_idx_d    = (beats == 32'd0) ? 32'd0 : beats - 32'd1;
            ops_d         = cfg_ops;
            offset_d      = cfg_offset;
            check_en_d    = cfg_check_en;
            armed_d       = 1'b0;
            cycles_d      = '0;
            err_cnt_d     = '0;
            err_index_d   = '0;
            err_sid_d     = '0;
            word_cnt_d    = '0;
            msg_cnt_d     = '0;
            bad_sid_cnt_d = '0;
            for (int i = 0; i < NUM_SESSIONS; i++)
                beat_cnt_d[i] = '0;
        end

        meta_ready_d = (state_d == ST_META);
        data_ready_d = (state_d == ST_DATA);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            meta_ready_q  <= 1'b0;
            data_ready_q  <= 1'b0;
            done_q        <= 1'b0;
            last_idx_q    <= '0;
            ops_q         <= '0;
            offset_q      <= '0;
            check_en_q    <= 1'b0;
            sid_q         <= '0;
            idx_q         <= '0;
            sid_ok_q      <= 1'b0;
            armed_q       <= 1'b0;
            cycles_q      <= '0;
            err_cnt_q     <= '0;
            err_index_q   <= '0;
            err_sid_q     <= '0;
            word_cnt_q    <= '0;
            msg_cnt_q     <= '0;
            bad_sid_cnt_q <= '0;
            for (int i = 0; i < NUM_SESSIONS; i++)
                beat_cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            meta_ready_q  <= meta_ready_d;
            data_ready_q  <= data_ready_d;
            done_q        <= done_d;
            last_idx_q    <= last_idx_d;
            ops_q         <= ops_d;
            offset_q      <= offset_d;
            check_en_q    <= check_en_d;
            sid_q         <= sid_d;
            idx_q         <= idx_d;
            sid_ok_q      <= sid_ok_d;
            armed_q       <= armed_d;
            cycles_q      <= cycles_d;
            err_cnt_q     <= err_cnt_d;
            err_index_q   <= err_index_d;
            err_sid_q     <= err_sid_d;
            word_cnt_q    <= word_cnt_d;
            msg_cnt_q     <= msg_cnt_d;
            bad_sid_cnt_q <= bad_sid_cnt_d;
            for (int i = 0; i < NUM_SESSIONS; i++)
                beat_cnt_q[i] <= beat_cnt_d[i];
        end
    end

    assign s_meta_ready     = meta_ready_q;
    assign s_data_ready     = data_ready_q;
    assign done             = done_q;
    assign stat_cycles      = cycles_q;
    assign stat_err_cnt     = err_cnt_q;
    assign stat_err_index   = err_index_q;
    assign stat_err_sid     = err_sid_q;
    assign stat_word_cnt    = word_cnt_q;
    assign stat_msg_cnt     = msg_cnt_q;
    assign stat_bad_sid_cnt = bad_sid_cnt_q;

endmodule

// File: tb/tb_tcp_rx_checker.sv
// Directed bench for tcp_rx_checker: table of full runs plus hand-written
// sequences for bad SID, cfg_ops==0, restart in DONE and reset mid-packet.
module tb_tcp_rx_checker;
    localparam int DW  = 512;
    localparam int NS  = 4;
    localparam int SW  = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_meta_valid;
    logic          s_meta_ready;
    logic [SW-1:0] s_meta_sid;
    logic          s_data_valid;
    logic          s_data_ready;
    logic [DW-1:0] s_data_data;
    logic          s_data_last;
    logic          start;
    logic [31:0]   cfg_msg_len, cfg_ops, cfg_offset;
    logic          cfg_check_en;
    logic [31:0]   stat_cycles, stat_err_cnt, stat_err_index;
    logic [SW-1:0] stat_err_sid;
    logic [31:0]   stat_word_cnt, stat_msg_cnt, stat_bad_sid_cnt;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tcp_rx_checker #(.DATA_WIDTH(DW), .NUM_SESSIONS(NS), .SID_WIDTH(SW)) dut (
        .clk(clk), .rstn(rstn),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_sid(s_meta_sid),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
        .s_data_data(s_data_data), .s_data_last(s_data_last),
        .start(start), .cfg_msg_len(cfg_msg_len), .cfg_ops(cfg_ops),
        .cfg_offset(cfg_offset), .cfg_check_en(cfg_check_en),
        .stat_cycles(stat_cycles), .stat_err_cnt(stat_err_cnt),
        .stat_err_index(stat_err_index), .stat_err_sid(stat_err_sid),
        .stat_word_cnt(stat_word_cnt), .stat_msg_cnt(stat_msg_cnt),
        .stat_bad_sid_cnt(stat_bad_sid_cnt), .done(done)
    );

    typedef struct {
        logic [31:0] msg_len;
        int          ops;
        logic [31:0] offset;
        logic        check_en;
        int          nsess;
        int          msg_beats;
        int          pkt_beats;
        int          err_msg;
        int          err_beat;
        logic [31:0] exp_msg;
        logic [31:0] exp_word;
        logic [31:0] exp_err;
        logic [31:0] exp_err_idx;
        logic [31:0] exp_err_sid;
        logic [31:0] exp_cycles;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // All tasks start and end at a negative clock edge.
    task automatic do_start(input logic [31:0] len, input logic [31:0] ops,
                            input logic [31:0] off, input logic en);
        cfg_msg_len = len; cfg_ops = ops; cfg_offset = off; cfg_check_en = en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_meta(input logic [SW-1:0] sid);
        int w = 0;
        s_meta_valid = 1'b1;
        s_meta_sid   = sid;
        while (!s_meta_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!s_meta_ready) begin
            n_chk++; n_fail++;
            $display("FAIL meta_handshake_timeout: got ready=0, expected ready=1");
        end
        @(negedge clk);
        s_meta_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] word, input logic last);
        int w = 0;
        s_data_valid = 1'b1;
        s_data_data  = {{(DW-32){1'b1}}, word};
        s_data_last  = last;
        while (!s_data_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!s_data_ready) begin
            n_chk++; n_fail++;
            $display("FAIL data_handshake_timeout: got ready=0, expected ready=1");
        end
        @(negedge clk);
        s_data_valid = 1'b0;
        s_data_last  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] word;
        int b;
        do_start(v.msg_len, v.ops, v.offset, v.check_en);
        for (int r = 0; r < v.ops / v.nsess; r++)
            for (int p = 0; p < v.msg_beats / v.pkt_beats; p++)
                for (int s = 0; s < v.nsess; s++) begin
                    send_meta(SW'(s));
                    for (int k = 0; k < v.pkt_beats; k++) begin
                        b = p * v.pkt_beats + k;
                        word = 32'(b) + v.offset;
                        if ((r * v.nsess + s) == v.err_msg && b == v.err_beat)
                            word = 32'hDEAD;
                        send_beat(word, k == v.pkt_beats - 1);
                    end
                end
    endtask

    initial begin
        logic [31:0] cyc_snap;
        rstn = 1'b0; start = 1'b0;
        s_meta_valid = 1'b0; s_meta_sid = '0;
        s_data_valid = 1'b0; s_data_data = '0; s_data_last = 1'b0;
        cfg_msg_len = '0; cfg_ops = '0; cfg_offset = '0; cfg_check_en = 1'b0;

        //          len   ops off     en ns mb  pb err_m err_b msg word err idx sid cycles
        vecs[0] = '{4096, 4, 32'h0,   1, 1, 64, 64, -1,   0,  4, 256, 0,  0, 0, 259};
        vecs[1] = '{4096, 4, 32'h0,   1, 1, 64, 64,  2,  10,  4, 256, 1, 10, 0, 259};
        vecs[2] = '{4096, 4, 32'h0,   0, 1, 64, 64,  2,  10,  4, 256, 0,  0, 0, 259};
        vecs[3] = '{4096, 4, 32'h100, 1, 2, 64, 16, -1,   0,  4, 256, 0,  0, 0, 271};
        vecs[4] = '{4096, 4, 32'h100, 1, 2, 64, 16,  1,  20,  4, 256, 1, 20, 1, 271};
        vecs[5] = '{32,   3, 32'h0,   1, 1,  1,  1, -1,   0,  3,   3, 0,  0, 0,   5};

        repeat (3) @(negedge clk);
        chk("reset_done", 32'(done), 0);
        chk("reset_meta_ready", 32'(s_meta_ready), 0);
        chk("reset_data_ready", 32'(s_data_ready), 0);
        chk("reset_word_cnt", stat_word_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_meta_ready", 32'(s_meta_ready), 0);

        for (int i = 0; i < 6; i++) begin
            $display("-- vector %0d", i);
            run_vec(vecs[i]);
            chk($sformatf("v%0d_done", i), 32'(done), 1);
            chk($sformatf("v%0d_msg_cnt", i), stat_msg_cnt, vecs[i].exp_msg);
            chk($sformatf("v%0d_word_cnt", i), stat_word_cnt, vecs[i].exp_word);
            chk($sformatf("v%0d_err_cnt", i), stat_err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_err_index", i), stat_err_index, vecs[i].exp_err_idx);
            chk($sformatf("v%0d_err_sid", i), 32'(stat_err_sid), vecs[i].exp_err_sid);
            chk($sformatf("v%0d_cycles", i), stat_cycles, vecs[i].exp_cycles);
            chk($sformatf("v%0d_bad_sid", i), stat_bad_sid_cnt, 0);
            cyc_snap = vecs[i].exp_cycles;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_cycles_frozen", i), stat_cycles, cyc_snap);
            chk($sformatf("v%0d_done_meta_ready", i), 32'(s_meta_ready), 0);
        end

        // Restart from DONE: everything clears and META is entered at once.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", 32'(done), 0);
        chk("restart_meta_ready", 32'(s_meta_ready), 1);
        chk("restart_data_ready", 32'(s_data_ready), 0);
        chk("restart_msg_cnt", stat_msg_cnt, 0);
        chk("restart_word_cnt", stat_word_cnt, 0);
        chk("restart_cycles", stat_cycles, 0);
        @(negedge clk);

        // Invalid SID packet drained and counted, then a normal single-message run.
        $display("-- bad sid");
        do_start(4096, 1, 0, 1'b1);
        send_meta(SW'(NS));
        chk("bad_sid_at_meta", stat_bad_sid_cnt, 1);
        for (int k = 0; k < 8; k++) send_beat(32'hFFFF_FFFF, k == 7);
        chk("bad_sid_not_done", 32'(done), 0);
        send_meta(SW'(0));
        for (int k = 0; k < 64; k++) send_beat(32'(k), k == 63);
        chk("bad_done", 32'(done), 1);
        chk("bad_bad_sid_cnt", stat_bad_sid_cnt, 1);
        chk("bad_word_cnt", stat_word_cnt, 72);
        chk("bad_msg_cnt", stat_msg_cnt, 1);
        chk("bad_err_cnt", stat_err_cnt, 0);
        chk("bad_cycles", stat_cycles, 73);

        // cfg_ops == 0: first packet drained, then DONE.
        $display("-- ops zero");
        do_start(4096, 0, 0, 1'b1);
        send_meta(SW'(1));
        for (int k = 0; k < 4; k++) send_beat(32'(k), k == 3);
        chk("ops0_done", 32'(done), 1);
        chk("ops0_msg_cnt", stat_msg_cnt, 0);
        chk("ops0_word_cnt", stat_word_cnt, 4);
        chk("ops0_err_cnt", stat_err_cnt, 0);

        // Reset for one cycle in the middle of a packet.
        $display("-- reset mid-packet");
        do_start(4096, 1, 0, 1'b1);
        send_meta(SW'(0));
        for (int k = 0; k < 5; k++) send_beat(32'(k), 1'b0);
        chk("mid_word_cnt", stat_word_cnt, 5);
        s_data_valid = 1'b1;
        s_data_data  = {{(DW-32){1'b0}}, 32'd5};
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        s_data_valid = 1'b0;
        chk("rst_data_ready", 32'(s_data_ready), 0);
        chk("rst_meta_ready", 32'(s_meta_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_word_cnt", stat_word_cnt, 0);
        chk("rst_cycles", stat_cycles, 0);
        @(negedge clk);
        chk("rst_idle_meta_ready", 32'(s_meta_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
